// File: rtl/bnn_fc_layer_pkg.sv
// Shared definitions for the binary fully-connected output layer:
// class count, score width, default input count, FSM encoding and
// the XNOR +/-1 step helper used by every class accumulator.
package bnn_fc_layer_pkg;

    localparam int N_CLASSES    = 10;
    localparam int ACC_W        = 10;
    localparam int N_IN_DEFAULT = 144;
    localparam int IDX_W        = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } fc_state_t;

    // A matching activation/weight pair votes +1, a mismatch votes -1.
    function automatic logic signed [ACC_W-1:0] xnorStep(input logic a, input logic w);
        return (a ~^ w) ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    endfunction

endpackage

// File: rtl/bnn_fc_layer_if.sv
// Bus between the activation/weight source plus controller (master)
// and the fully-connected layer (slave).
interface bnn_fc_layer_if;
    import bnn_fc_layer_pkg::*;

    logic                    start;
    logic                    act_in;
    logic                    act_valid;
    logic [N_CLASSES-1:0]    weight_in;
    logic [IDX_W-1:0]        in_idx;
    logic                    busy;
    logic signed [ACC_W-1:0] fc_result_0;
    logic signed [ACC_W-1:0] fc_result_1;
    logic signed [ACC_W-1:0] fc_result_2;
    logic signed [ACC_W-1:0] fc_result_3;
    logic signed [ACC_W-1:0] fc_result_4;
    logic signed [ACC_W-1:0] fc_result_5;
    logic signed [ACC_W-1:0] fc_result_6;
    logic signed [ACC_W-1:0] fc_result_7;
    logic signed [ACC_W-1:0] fc_result_8;
    logic signed [ACC_W-1:0] fc_result_9;
    logic                    fc_result_valid;

    modport master (
        output start, act_in, act_valid, weight_in,
        input  in_idx, busy,
        input  fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
        input  fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9,
        input  fc_result_valid
    );

    modport slave (
        input  start, act_in, act_valid, weight_in,
        output in_idx, busy,
        output fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
        output fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9,
        output fc_result_valid
    );

endinterface

// File: rtl/bnn_fc_layer_neuron.sv
// One class accumulator: signed score that steps +1/-1 per accepted
// activation depending on whether activation and weight bit agree.
module bnn_fc_neuron
    import bnn_fc_layer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic                    i_act,
    input  logic                    i_weight,
    output logic signed [ACC_W-1:0] o_score
);

    logic signed [ACC_W-1:0] r_score;

    // Clear beats enable so a restart never folds in a stale vote.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_score <= '0;
        end else if (i_en) begin
            r_score <= r_score + xnorStep(i_act, i_weight);
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/bnn_fc_layer.sv
// Binary fully-connected output layer: counts accepted activations,
// drives the weight ROM address, and holds ten class scores once the
// last input of the image has been accumulated.
module bnn_fc_layer
    import bnn_fc_layer_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst,
    bnn_fc_layer_if.slave bus
);

    fc_state_t               r_state;
    fc_state_t               w_next_state;
    logic [IDX_W-1:0]        r_in_idx;
    logic                    w_clear;
    logic                    w_accept;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_score [N_CLASSES];

    // Start always clears and wins over a coincident activation; inputs
    // are only consumed while accumulating.
    always_comb begin
        w_clear      = bus.start;
        w_accept     = (r_state == ST_ACC) && bus.act_valid && !bus.start;
        w_last       = w_accept && (r_in_idx == IDX_W'(N_IN - 1));
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next_state = ST_ACC;
            ST_ACC: begin
                if (bus.start)   w_next_state = ST_ACC;
                else if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: if (bus.start) w_next_state = ST_ACC;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Input index doubles as the weight ROM address; frozen outside ACC.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_in_idx <= '0;
        end else if (w_accept) begin
            r_in_idx <= r_in_idx + IDX_W'(1);
        end
    end

    for (genvar k = 0; k < N_CLASSES; k++) begin : g_neuron
        bnn_fc_neuron u_neuron (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_clear),
            .i_en     (w_accept),
            .i_act    (bus.act_in),
            .i_weight (bus.weight_in[k]),
            .o_score  (w_score[k])
        );
    end

    assign bus.in_idx          = r_in_idx;
    assign bus.busy            = (r_state == ST_ACC);
    assign bus.fc_result_valid = (r_state == ST_DONE);
    assign bus.fc_result_0     = w_score[0];
    assign bus.fc_result_1     = w_score[1];
    assign bus.fc_result_2     = w_score[2];
    assign bus.fc_result_3     = w_score[3];
    assign bus.fc_result_4     = w_score[4];
    assign bus.fc_result_5     = w_score[5];
    assign bus.fc_result_6     = w_score[6];
    assign bus.fc_result_7     = w_score[7];
    assign bus.fc_result_8     = w_score[8];
    assign bus.fc_result_9     = w_score[9];

endmodule

// File: tb/tb_bnn_fc_layer.sv
// Scoreboard bench for bnn_fc_layer: the stimulus side pushes expected
// scores for every completed image, a monitor pops and compares them
// whenever the layer raises its result valid.
module tb_bnn_fc_layer;

    localparam int NIN = 144;

    typedef struct packed {
        logic [9:0][9:0] score;
        logic [8:0]      idx;
    } exp_t;

    logic clk;
    logic rst;
    bnn_fc_layer_if bus();

    bnn_fc_layer #(.N_IN(NIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t              expQ[$];
    int                total;
    int                bad;
    int                modelScore [10];
    int                modelIdx;
    logic signed [9:0] dutRes [10];
    logic              prevValid;

    assign dutRes[0] = bus.fc_result_0;
    assign dutRes[1] = bus.fc_result_1;
    assign dutRes[2] = bus.fc_result_2;
    assign dutRes[3] = bus.fc_result_3;
    assign dutRes[4] = bus.fc_result_4;
    assign dutRes[5] = bus.fc_result_5;
    assign dutRes[6] = bus.fc_result_6;
    assign dutRes[7] = bus.fc_result_7;
    assign dutRes[8] = bus.fc_result_8;
    assign dutRes[9] = bus.fc_result_9;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs without touching the reference model.
    task automatic driveRaw(input logic st, input logic vld, input logic act, input logic [9:0] w);
        @(negedge clk);
        bus.start     = st;
        bus.act_valid = vld;
        bus.act_in    = act;
        bus.weight_in = w;
    endtask

    // One accepted activation; the reference model votes alongside.
    task automatic applyStimulus(input logic act, input logic [9:0] w);
        driveRaw(1'b0, 1'b1, act, w);
        for (int k = 0; k < 10; k++) begin
            modelScore[k] += ((act ~^ w[k]) != 1'b0) ? 1 : -1;
        end
        modelIdx++;
    endtask

    task automatic startImage();
        driveRaw(1'b1, 1'b0, 1'b0, 10'h000);
        for (int k = 0; k < 10; k++) modelScore[k] = 0;
        modelIdx = 0;
    endtask

    task automatic feedImage(input logic act, input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) applyStimulus(act, w);
    endtask

    // Called right after the last input is presented: queue the model's
    // result, then confirm valid rises exactly one cycle later.
    task automatic finishImage(input string tag);
        exp_t e;
        checkOutput({tag, "_valid_before_last"}, int'(bus.fc_result_valid), 0);
        for (int k = 0; k < 10; k++) e.score[k] = 10'(modelScore[k]);
        e.idx = 9'(modelIdx);
        expQ.push_back(e);
        driveRaw(1'b0, 1'b0, 1'b0, 10'h000);
        checkOutput({tag, "_valid_after_last"}, int'(bus.fc_result_valid), 1);
        checkOutput({tag, "_busy_done"}, int'(bus.busy), 0);
    endtask

    task automatic checkCleared(input string tag, input int expBusy);
        checkOutput({tag, "_busy"}, int'(bus.busy), expBusy);
        checkOutput({tag, "_valid"}, int'(bus.fc_result_valid), 0);
        checkOutput({tag, "_idx"}, int'(bus.in_idx), 0);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("%s_score%0d", tag, k), int'(dutRes[k]), 0);
        end
    endtask

    // Monitor: every rising edge of valid must match the oldest queued image.
    initial begin
        exp_t e;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fc_result_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    for (int k = 0; k < 10; k++) begin
                        checkOutput($sformatf("sb_score%0d", k), int'(dutRes[k]), int'($signed(e.score[k])));
                    end
                    checkOutput("sb_in_idx", int'(bus.in_idx), int'(e.idx));
                end
            end
            prevValid = bus.fc_result_valid;
        end
    end

    // Directed sequence.
    initial begin
        int n;
        total         = 0;
        bad           = 0;
        modelIdx      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.act_valid = 1'b0;
        bus.act_in    = 1'b0;
        bus.weight_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCleared("reset", 0);

        // All weights agree with +1 activations: every class scores +144.
        startImage();
        feedImage(1'b1, 10'h3FF, NIN);
        finishImage("all_pos");

        // Restart from DONE drops valid and clears; all disagree: -144.
        startImage();
        driveRaw(1'b0, 1'b0, 1'b0, 10'h000);
        checkCleared("restart", 1);
        feedImage(1'b1, 10'h000, NIN);
        finishImage("all_neg");
        checkOutput("all_neg_hex", int'(bus.fc_result_0[9:0]), 'h370);

        // Only class 0 agrees; scores must hold for 20 cycles in DONE
        // even with act_valid toggling.
        startImage();
        feedImage(1'b1, 10'h001, NIN);
        finishImage("class0");
        for (int c = 0; c < 20; c++) begin
            driveRaw(1'b0, 1'(c % 2), 1'b1, 10'h3FF);
            checkOutput("hold_valid", int'(bus.fc_result_valid), 1);
            checkOutput("hold_idx", int'(bus.in_idx), NIN);
            checkOutput("hold_score0", int'(dutRes[0]), 144);
            checkOutput("hold_score9", int'(dutRes[9]), -144);
        end

        // Random gaps and weights against the reference model.
        startImage();
        n = 0;
        while (n < NIN) begin
            if ($urandom_range(0, 2) == 0) begin
                driveRaw(1'b0, 1'b0, 1'($urandom), 10'($urandom));
            end else begin
                applyStimulus(1'($urandom), 10'($urandom));
                n++;
            end
        end
        finishImage("random");

        // Abort after 50 inputs: coincident input dropped, fresh image needed.
        startImage();
        feedImage(1'b1, 10'h3FF, 50);
        driveRaw(1'b1, 1'b1, 1'b1, 10'h3FF);
        for (int k = 0; k < 10; k++) modelScore[k] = 0;
        modelIdx = 0;
        driveRaw(1'b0, 1'b0, 1'b0, 10'h000);
        checkCleared("abort", 1);
        feedImage(1'b0, 10'h2AA, NIN);
        finishImage("after_abort");
        checkOutput("after_abort_score0", int'(dutRes[0]), 144);
        checkOutput("after_abort_score1", int'(dutRes[1]), -144);

        // Start coincident with the final input: start wins, no DONE.
        startImage();
        feedImage(1'b1, 10'h3FF, NIN - 1);
        driveRaw(1'b1, 1'b1, 1'b1, 10'h3FF);
        driveRaw(1'b0, 1'b0, 1'b0, 10'h000);
        checkCleared("start_vs_last", 1);

        // Reset at input 100 discards everything; act_valid alone is ignored.
        startImage();
        feedImage(1'b1, 10'h155, 100);
        @(negedge clk);
        bus.act_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkCleared("mid_reset", 0);
        for (int i = 0; i < 5; i++) driveRaw(1'b0, 1'b1, 1'b1, 10'h3FF);
        driveRaw(1'b0, 1'b0, 1'b0, 10'h000);
        checkCleared("idle_ignore", 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
